// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with oversampling by CLK_PER_BIT.
// Incoming line is double-synchronized; every sample is taken near the
// centre of its bit cell. A good stop bit loads data and pulses new_data,
// a low stop bit pulses frame_error and waits for the line to go idle.
module serial_rx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_error
);

  localparam int unsigned CTR_W = $clog2(CLK_PER_BIT);

  // Terminal counts for a half bit (start check) and a full bit cell.
  localparam logic [CTR_W-1:0] CTR_HALF_END = CTR_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] CTR_BIT_END  = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [CTR_W-1:0] CTR_ONE      = CTR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CTR_W-1:0] ctr, ctr_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             new_data_n;
  logic             frame_error_n;

  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, timing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ctr         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data        <= '0;
      new_data    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      ctr         <= ctr_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data        <= data_n;
      new_data    <= new_data_n;
      frame_error <= frame_error_n;
    end
  end

  // Next-state and next-output logic for the frame receiver.
  always_comb begin
    state_n       = state;
    ctr_n         = ctr;
    bit_idx_n     = bit_idx;
    shift_n       = shift;
    data_n        = data;
    new_data_n    = 1'b0;
    frame_error_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          ctr_n   = '0;
        end
      end

      START: begin
        ctr_n = ctr + CTR_ONE;
        if (ctr == CTR_HALF_END) begin
          if (!rx_s) begin
            state_n   = DATA;
            ctr_n     = '0;
            bit_idx_n = '0;
          end else begin
            // Line went back high before mid-start: glitch, not a frame.
            state_n = IDLE;
          end
        end
      end

      DATA: begin
        ctr_n = ctr + CTR_ONE;
        if (ctr == CTR_BIT_END) begin
          shift_n[bit_idx] = rx_s;
          ctr_n            = '0;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end

      STOP: begin
        ctr_n = ctr + CTR_ONE;
        if (ctr == CTR_BIT_END) begin
          ctr_n = '0;
          // Leaving at the stop centre lets an immediately following
          // start bit be seen without an idle gap.
          if (rx_s) begin
            data_n     = shift;
            new_data_n = 1'b1;
            state_n    = IDLE;
          end else begin
            frame_error_n = 1'b1;
            state_n       = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: two instances (16 and 5 clocks per bit) driven
// with directed and random 8N1 frames, checked against a byte-queue model.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1;
  logic       rx5 = 1'b1;
  logic [7:0] data16, data5;
  logic       new_data16, new_data5;
  logic       frame_error16, frame_error5;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed strobes (collected by monitors).
  logic [7:0] got16[$];
  logic [7:0] got5[$];
  int fe16 = 0, fe5 = 0;
  int long16 = 0, long5 = 0;
  int both16 = 0, both5 = 0;
  int bad16 = 0, bad5 = 0;

  // Reference model: bytes expected to be delivered, errors, held data.
  logic [7:0] exp16[$];
  logic [7:0] exp5[$];
  int         exp_fe16 = 0, exp_fe5 = 0;
  logic [7:0] exp_data16 = 8'h00, exp_data5 = 8'h00;

  serial_rx #(.CLK_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16),
    .data(data16), .new_data(new_data16), .frame_error(frame_error16)
  );

  serial_rx #(.CLK_PER_BIT(5)) dut5 (
    .clk(clk), .rst(rst), .rx(rx5),
    .data(data5), .new_data(new_data5), .frame_error(frame_error5)
  );

  always #5 clk = ~clk;

  // Monitors sample on the falling edge, away from DUT updates.
  logic       rst_d = 1'b1;
  logic       nd16_d = 1'b0, nd5_d = 1'b0, fe16_d = 1'b0, fe5_d = 1'b0;
  logic [7:0] d16_d, d5_d;

  always @(negedge clk) begin
    if (!rst_d) begin
      if (new_data16) got16.push_back(data16);
      if (frame_error16) fe16++;
      if ((new_data16 && nd16_d) || (frame_error16 && fe16_d)) long16++;
      if (new_data16 && frame_error16) both16++;
      if (!new_data16 && data16 !== d16_d) bad16++;
      if (new_data5) got5.push_back(data5);
      if (frame_error5) fe5++;
      if ((new_data5 && nd5_d) || (frame_error5 && fe5_d)) long5++;
      if (new_data5 && frame_error5) both5++;
      if (!new_data5 && data5 !== d5_d) bad5++;
    end
    rst_d  <= rst;
    nd16_d <= new_data16;
    nd5_d  <= new_data5;
    fe16_d <= frame_error16;
    fe5_d  <= frame_error5;
    d16_d  <= data16;
    d5_d   <= data5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit sel5, input logic v);
    if (sel5) rx5 = v;
    else rx16 = v;
  endtask

  // One 8N1 frame; the stop level is held stop_len cycles, then the line
  // is left high.
  task automatic send(input bit sel5, input logic [7:0] b, input bit stop_ok,
                      input int stop_len);
    int n;
    n = sel5 ? 5 : 16;
    drive(sel5, 1'b0);
    tick(n);
    for (int i = 0; i < 8; i++) begin
      drive(sel5, b[i]);
      tick(n);
    end
    drive(sel5, stop_ok);
    tick(stop_len);
    drive(sel5, 1'b1);
  endtask

  // Model: a good stop delivers the byte, a bad stop only counts an error.
  task automatic model(input bit sel5, input logic [7:0] b, input bit stop_ok);
    if (sel5) begin
      if (stop_ok) begin exp5.push_back(b); exp_data5 = b; end
      else exp_fe5++;
    end else begin
      if (stop_ok) begin exp16.push_back(b); exp_data16 = b; end
      else exp_fe16++;
    end
  endtask

  task automatic verify(input bit sel5, input string tag);
    int gs, es;
    logic [7:0] g, e;
    gs = sel5 ? got5.size() : got16.size();
    es = sel5 ? exp5.size() : exp16.size();
    check({tag, "_count"}, gs, es);
    while (gs > 0 && es > 0) begin
      if (sel5) begin g = got5.pop_front(); e = exp5.pop_front(); end
      else begin g = got16.pop_front(); e = exp16.pop_front(); end
      check({tag, "_byte"}, {24'd0, g}, {24'd0, e});
      gs--;
      es--;
    end
    if (sel5) begin
      got5.delete(); exp5.delete();
      check({tag, "_ferr"}, fe5, exp_fe5);
      check({tag, "_data"}, {24'd0, data5}, {24'd0, exp_data5});
    end else begin
      got16.delete(); exp16.delete();
      check({tag, "_ferr"}, fe16, exp_fe16);
      check({tag, "_data"}, {24'd0, data16}, {24'd0, exp_data16});
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] seq4 [4];
    bit         ok;
    int         gap;

    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_data16", {24'd0, data16}, 32'h00);
    check("reset_nd16", {31'd0, new_data16}, 32'd0);
    check("reset_fe16", {31'd0, frame_error16}, 32'd0);
    check("reset_data5", {24'd0, data5}, 32'h00);

    // Single good byte.
    send(1'b0, 8'h2A, 1'b1, 16);
    model(1'b0, 8'h2A, 1'b1);
    tick(40);
    verify(1'b0, "basic_2a");

    // Short low glitch must not start a frame.
    drive(1'b0, 1'b0);
    tick(4);
    drive(1'b0, 1'b1);
    tick(40);
    verify(1'b0, "glitch");

    // Low stop bit held two cells, then a good byte.
    send(1'b0, 8'h55, 1'b0, 32);
    model(1'b0, 8'h55, 1'b0);
    tick(40);
    verify(1'b0, "frame_err");
    send(1'b0, 8'h2A, 1'b1, 16);
    model(1'b0, 8'h2A, 1'b1);
    tick(40);
    verify(1'b0, "after_ferr");

    // Back-to-back frames with one stop bit and no idle.
    seq4[0] = 8'h2A; seq4[1] = 8'h00; seq4[2] = 8'hFF; seq4[3] = 8'h2A;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, seq4[i], 1'b1, 16);
      model(1'b0, seq4[i], 1'b1);
    end
    tick(40);
    verify(1'b0, "b2b");

    // Reset in the middle of data bit 4 of A5.
    drive(1'b0, 1'b0);
    tick(16);
    b = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, b[i]);
      tick(16);
    end
    drive(1'b0, b[4]);
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    drive(1'b0, 1'b1);
    exp_data16 = 8'h00;
    exp_data5  = 8'h00;
    tick(40);
    verify(1'b0, "mid_reset");
    send(1'b0, 8'h3C, 1'b1, 16);
    model(1'b0, 8'h3C, 1'b1);
    tick(40);
    verify(1'b0, "post_reset");

    // Minimum-margin odd bit period.
    send(1'b1, 8'h2A, 1'b1, 5);
    model(1'b1, 8'h2A, 1'b1);
    tick(20);
    verify(1'b1, "cpb5_2a");

    // Random traffic at 16 clocks per bit, including bad stop bits.
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin
        send(1'b0, b, 1'b1, 16);
        gap = $urandom_range(0, 16);
      end else begin
        send(1'b0, b, 1'b0, 32);
        gap = $urandom_range(16, 40);
      end
      model(1'b0, b, ok);
      tick(gap);
    end
    tick(40);
    verify(1'b0, "rand16");

    // Random good traffic at 5 clocks per bit.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send(1'b1, b, 1'b1, 5);
      model(1'b1, b, 1'b1);
      tick($urandom_range(0, 5));
    end
    tick(20);
    verify(1'b1, "rand5");

    check("strobe_width16", long16, 0);
    check("strobe_width5", long5, 0);
    check("strobe_both16", both16, 0);
    check("strobe_both5", both5, 0);
    check("data_hold16", bad16, 0);
    check("data_hold5", bad5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 100, giving clk cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port data  output  8  last correctly framed byte received.
REQ-006 SHALL have port new_data  output  1  single-cycle strobe marking data as freshly updated.
REQ-007 SHALL have port frame_error  output  1  single-cycle strobe marking a byte rejected for a low stop bit.

Function
REQ-008 SHALL pass rx through a two-flop synchronizer (rx_s); both flops reset to 1; all decisions use rx_s only.
REQ-009 SHALL size its bit-timing counter ctr to clog2(CLK_PER_BIT) bits and its bit index to 3 bits.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-011 IDLE: on rx_s==0, go to START with ctr=0; otherwise stay.
REQ-012 START: increment ctr; on ctr==CLK_PER_BIT/2-1 (integer division), if rx_s==0 go to DATA with ctr=0 and bit index=0, else treat as a glitch and go to IDLE.
REQ-013 DATA: increment ctr; on ctr==CLK_PER_BIT-1, set shift[bit index]=rx_s, reset ctr=0 and increment bit index; after bit index 7 is sampled, go to STOP.
REQ-014 STOP: increment ctr; on ctr==CLK_PER_BIT-1, sample rx_s, then:
  - rx_s==1: load data<=shift and go to IDLE.
  - rx_s==0: leave data unchanged and go to WAIT_IDLE.
REQ-015 WAIT_IDLE: stay until rx_s==1, then go to IDLE; a low line SHALL never be taken as a new start bit while in this state.
REQ-016 new_data SHALL be 1 for exactly the one cycle after a good stop-bit sample (the cycle data first shows the new byte), and 0 otherwise.
REQ-017 frame_error SHALL be 1 for exactly the one cycle after a low stop-bit sample, and 0 otherwise; new_data and frame_error SHALL never both be 1.
REQ-018 Every sample (start check, 8 data bits, stop bit) SHALL fall at the bit-cell centre, ±1 cycle.
REQ-019 SHALL return to IDLE at the stop-bit centre, so a start bit immediately following one stop bit is caught; back-to-back bytes with no idle gap SHALL all be received.
REQ-020 data SHALL hold its value between strobes; no output other than the strobes changes outside a good stop sample.
REQ-021 Latency: new_data SHALL assert 2 (synchronizer) + 1 cycles after the rx stop-bit centre.

Reset
REQ-022 When rst==1 at a clock edge, SHALL set: state=IDLE, ctr=0, bit index=0, shift=0, data=8'h00, new_data=0, frame_error=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abandon the byte with no strobe; the first falling edge after rst deasserts starts a fresh frame.
REQ-024 rst SHALL take priority over every other condition in the same cycle.

Verification
REQ-025 CLK_PER_BIT=16, send 8'h2A framed 8N1 -> data==8'h2A, new_data high for exactly 1 cycle, frame_error stays 0.
REQ-026 rx low for 4 cycles then high -> no new_data, no frame_error, state back in IDLE, data unchanged.
REQ-027 Send 8'h55 with the stop bit held low 32 cycles -> frame_error pulses once, data keeps its previous value, no new_data; a following good 8'h2A -> data==8'h2A.
REQ-028 Back-to-back 8'h2A, 8'h00, 8'hFF, 8'h2A with one stop bit each and no idle gap -> four new_data pulses with data 2A, 00, FF, 2A in order.
REQ-029 rst pulsed during data bit 4 of 8'hA5, then 8'h3C sent -> no strobe for A5, data==8'h00 after reset, then data==8'h3C with one new_data pulse.
REQ-030 Repeat REQ-025 at CLK_PER_BIT=5 (odd, minimum-margin timing) -> data==8'h2A received correctly.
